// File: rtl/falling_piece_controller.sv
// Falling-tetromino sequencer: origin/orientation/type registers, action arbitration, gravity, lock delay.
// Define LOCK_RESET_LIMIT_EN to cap the number of lock-timer resets per piece at LOCK_RESETS.
module falling_piece_controller #(
  parameter int GRAVITY_TICKS = 25_000_000,
  parameter int LOCK_TICKS = 12_500_000,
`ifdef LOCK_RESET_LIMIT_EN
  parameter int LOCK_RESETS = 15,
`endif
  parameter logic [4:0] SPAWN_ROW = 5'd0,
  parameter logic [4:0] SPAWN_COL = 5'd4
) (
  input  logic       i_clk,
  input  logic       i_rst_l,
  input  logic       i_spawn_valid,
  input  logic [2:0] i_spawn_type,
  output logic       o_spawn_ready,
  input  logic       i_rotate_R,
  input  logic       i_rotate_L,
  input  logic       i_move_R,
  input  logic       i_move_L,
  input  logic       i_soft_drop,
  input  logic       i_hard_drop,
  input  logic       i_rotate_R_valid,
  input  logic       i_rotate_L_valid,
  input  logic       i_move_R_valid,
  input  logic       i_move_L_valid,
  input  logic       i_soft_drop_valid,
  input  logic [4:0] i_rotate_R_row_kick,
  input  logic [4:0] i_rotate_R_col_kick,
  input  logic [4:0] i_rotate_L_row_kick,
  input  logic [4:0] i_rotate_L_col_kick,
  input  logic [4:0] i_hard_drop_row,
  output logic [4:0] o_falling_row,
  output logic [4:0] o_falling_col,
  output logic [1:0] o_falling_orientation,
  output logic [2:0] o_falling_type,
  output logic       o_falling_active,
  output logic [4:0] o_cand_rotate_R_row,
  output logic [4:0] o_cand_rotate_R_col,
  output logic [1:0] o_cand_rotate_R_orientation,
  output logic [4:0] o_cand_rotate_L_row,
  output logic [4:0] o_cand_rotate_L_col,
  output logic [1:0] o_cand_rotate_L_orientation,
  output logic [4:0] o_cand_move_R_row,
  output logic [4:0] o_cand_move_R_col,
  output logic [1:0] o_cand_move_R_orientation,
  output logic [4:0] o_cand_move_L_row,
  output logic [4:0] o_cand_move_L_col,
  output logic [1:0] o_cand_move_L_orientation,
  output logic [4:0] o_cand_soft_drop_row,
  output logic [4:0] o_cand_soft_drop_col,
  output logic [1:0] o_cand_soft_drop_orientation,
  output logic       o_lock_req,
  input  logic       i_lock_ack
);

  localparam int GW = (GRAVITY_TICKS > 1) ? $clog2(GRAVITY_TICKS) : 1;
  localparam int LW = (LOCK_TICKS > 1) ? $clog2(LOCK_TICKS) : 1;
  localparam logic [GW-1:0] GRAV_MAX = GW'(GRAVITY_TICKS - 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_TICKS - 1);
  localparam logic [2:0] TYPE_BLANK = 3'd0;
  localparam logic [1:0] ORIENT_0 = 2'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_FALLING, ST_LOCKING, ST_LOCK_OUT} state_t;

  state_t          r_state, w_state_next;
  logic [4:0]      r_row, w_row_next;
  logic [4:0]      r_col, w_col_next;
  logic [1:0]      r_ori, w_ori_next;
  logic [2:0]      r_type, w_type_next;
  logic [GW-1:0]   r_grav, w_grav_next;
  logic [LW-1:0]   r_lock, w_lock_next;
`ifdef LOCK_RESET_LIMIT_EN
  logic [3:0]      r_resets, w_resets_next;
`endif

  logic            w_mv_ok;
  logic [4:0]      w_mv_row;
  logic [4:0]      w_mv_col;
  logic [1:0]      w_mv_ori;
  logic            w_any_act;
  logic            w_sd_selected;
  logic            w_grav_exp;

  assign o_cand_rotate_R_row         = r_row;
  assign o_cand_rotate_R_col         = r_col;
  assign o_cand_rotate_R_orientation = r_ori + 2'd1;
  assign o_cand_rotate_L_row         = r_row;
  assign o_cand_rotate_L_col         = r_col;
  assign o_cand_rotate_L_orientation = r_ori - 2'd1;
  assign o_cand_move_R_row           = r_row;
  assign o_cand_move_R_col           = r_col + 5'd1;
  assign o_cand_move_R_orientation   = r_ori;
  assign o_cand_move_L_row           = r_row;
  assign o_cand_move_L_col           = r_col - 5'd1;
  assign o_cand_move_L_orientation   = r_ori;
  assign o_cand_soft_drop_row        = r_row + 5'd1;
  assign o_cand_soft_drop_col        = r_col;
  assign o_cand_soft_drop_orientation = r_ori;

  assign o_falling_row         = r_row;
  assign o_falling_col         = r_col;
  assign o_falling_orientation = r_ori;
  assign o_falling_type        = r_type;

  assign w_any_act = i_hard_drop | i_rotate_R | i_rotate_L | i_move_R | i_move_L | i_soft_drop;
  assign w_sd_selected = i_soft_drop & ~(i_hard_drop | i_rotate_R | i_rotate_L | i_move_R | i_move_L);
  assign w_grav_exp = (r_grav == GRAV_MAX);

  // Winning move/rotation (hard_drop masks all of them); only the winner's valid is consulted.
  always_comb begin
    w_mv_ok  = 1'b0;
    w_mv_row = r_row;
    w_mv_col = r_col;
    w_mv_ori = r_ori;
    if (i_hard_drop) begin
      w_mv_ok = 1'b0;
    end else if (i_rotate_R) begin
      if (i_rotate_R_valid) begin
        w_mv_ok  = 1'b1;
        w_mv_row = i_rotate_R_row_kick;
        w_mv_col = i_rotate_R_col_kick;
        w_mv_ori = o_cand_rotate_R_orientation;
      end
    end else if (i_rotate_L) begin
      if (i_rotate_L_valid) begin
        w_mv_ok  = 1'b1;
        w_mv_row = i_rotate_L_row_kick;
        w_mv_col = i_rotate_L_col_kick;
        w_mv_ori = o_cand_rotate_L_orientation;
      end
    end else if (i_move_R) begin
      if (i_move_R_valid) begin
        w_mv_ok  = 1'b1;
        w_mv_col = o_cand_move_R_col;
      end
    end else if (i_move_L) begin
      if (i_move_L_valid) begin
        w_mv_ok  = 1'b1;
        w_mv_col = o_cand_move_L_col;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      r_state  <= ST_IDLE;
      r_row    <= SPAWN_ROW;
      r_col    <= SPAWN_COL;
      r_ori    <= ORIENT_0;
      r_type   <= TYPE_BLANK;
      r_grav   <= '0;
      r_lock   <= '0;
`ifdef LOCK_RESET_LIMIT_EN
      r_resets <= '0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_row    <= w_row_next;
      r_col    <= w_col_next;
      r_ori    <= w_ori_next;
      r_type   <= w_type_next;
      r_grav   <= w_grav_next;
      r_lock   <= w_lock_next;
`ifdef LOCK_RESET_LIMIT_EN
      r_resets <= w_resets_next;
`endif
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_row_next    = r_row;
    w_col_next    = r_col;
    w_ori_next    = r_ori;
    w_type_next   = r_type;
    w_grav_next   = r_grav;
    w_lock_next   = r_lock;
`ifdef LOCK_RESET_LIMIT_EN
    w_resets_next = r_resets;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_spawn_valid) begin
          w_type_next   = i_spawn_type;
          w_row_next    = SPAWN_ROW;
          w_col_next    = SPAWN_COL;
          w_ori_next    = ORIENT_0;
          w_grav_next   = '0;
          w_lock_next   = '0;
`ifdef LOCK_RESET_LIMIT_EN
          w_resets_next = '0;
`endif
          w_state_next  = ST_FALLING;
        end
      end
      ST_FALLING: begin
        if (i_hard_drop) begin
          w_row_next   = i_hard_drop_row;
          w_state_next = ST_LOCK_OUT;
        end else if (w_sd_selected || (!w_any_act && w_grav_exp)) begin
          w_grav_next = '0;
          if (i_soft_drop_valid) begin
            w_row_next = o_cand_soft_drop_row;
          end else begin
            w_lock_next  = '0;
            w_state_next = ST_LOCKING;
          end
        end else begin
          w_row_next = w_mv_row;
          w_col_next = w_mv_col;
          w_ori_next = w_mv_ori;
          // A user action on the expiry cycle parks the counter so gravity fires next cycle.
          w_grav_next = w_grav_exp ? r_grav : r_grav + GW'(1);
        end
      end
      ST_LOCKING: begin
        if (i_hard_drop) begin
          w_row_next   = i_hard_drop_row;
          w_state_next = ST_LOCK_OUT;
        end else if (w_mv_ok) begin
          w_row_next = w_mv_row;
          w_col_next = w_mv_col;
          w_ori_next = w_mv_ori;
`ifdef LOCK_RESET_LIMIT_EN
          if (r_resets < 4'(LOCK_RESETS)) begin
            w_lock_next   = '0;
            w_resets_next = r_resets + 4'd1;
          end else if (r_lock == LOCK_MAX) begin
            w_state_next = ST_LOCK_OUT;
          end else begin
            w_lock_next = r_lock + LW'(1);
          end
`else
          w_lock_next = '0;
`endif
        end else if (i_soft_drop_valid) begin
          w_lock_next  = '0;
          w_state_next = ST_FALLING;
        end else if (r_lock == LOCK_MAX) begin
          w_state_next = ST_LOCK_OUT;
        end else begin
          w_lock_next = r_lock + LW'(1);
        end
      end
      ST_LOCK_OUT: begin
        if (i_lock_ack) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_spawn_ready    = 1'b0;
    o_falling_active = 1'b0;
    o_lock_req       = 1'b0;
    case (r_state)
      ST_IDLE:     o_spawn_ready = 1'b1;
      ST_FALLING:  o_falling_active = 1'b1;
      ST_LOCKING:  o_falling_active = 1'b1;
      ST_LOCK_OUT: o_lock_req = 1'b1;
      default:     o_spawn_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_falling_piece_controller.sv
// Directed bench for falling_piece_controller with GRAVITY_TICKS=4, LOCK_TICKS=3 (LOCK_RESETS=2 when limited).
module tb_falling_piece_controller;

  logic       clk;
  logic       rst_l;
  logic       spawn_valid;
  logic [2:0] spawn_type;
  logic       spawn_ready;
  logic       rotate_R, rotate_L, move_R, move_L, soft_drop, hard_drop;
  logic       rotate_R_valid, rotate_L_valid, move_R_valid, move_L_valid, soft_drop_valid;
  logic [4:0] rotate_R_row_kick, rotate_R_col_kick, rotate_L_row_kick, rotate_L_col_kick;
  logic [4:0] hard_drop_row;
  logic [4:0] falling_row, falling_col;
  logic [1:0] falling_orientation;
  logic [2:0] falling_type;
  logic       falling_active;
  logic [4:0] c_rr_row, c_rr_col, c_rl_row, c_rl_col, c_mr_row, c_mr_col;
  logic [4:0] c_ml_row, c_ml_col, c_sd_row, c_sd_col;
  logic [1:0] c_rr_ori, c_rl_ori, c_mr_ori, c_ml_ori, c_sd_ori;
  logic       lock_req;
  logic       lock_ack;

  int checks = 0;
  int failures = 0;

  falling_piece_controller #(
    .GRAVITY_TICKS(4),
    .LOCK_TICKS(3),
`ifdef LOCK_RESET_LIMIT_EN
    .LOCK_RESETS(2),
`endif
    .SPAWN_ROW(5'd0),
    .SPAWN_COL(5'd4)
  ) dut (
    .i_clk(clk),
    .i_rst_l(rst_l),
    .i_spawn_valid(spawn_valid),
    .i_spawn_type(spawn_type),
    .o_spawn_ready(spawn_ready),
    .i_rotate_R(rotate_R),
    .i_rotate_L(rotate_L),
    .i_move_R(move_R),
    .i_move_L(move_L),
    .i_soft_drop(soft_drop),
    .i_hard_drop(hard_drop),
    .i_rotate_R_valid(rotate_R_valid),
    .i_rotate_L_valid(rotate_L_valid),
    .i_move_R_valid(move_R_valid),
    .i_move_L_valid(move_L_valid),
    .i_soft_drop_valid(soft_drop_valid),
    .i_rotate_R_row_kick(rotate_R_row_kick),
    .i_rotate_R_col_kick(rotate_R_col_kick),
    .i_rotate_L_row_kick(rotate_L_row_kick),
    .i_rotate_L_col_kick(rotate_L_col_kick),
    .i_hard_drop_row(hard_drop_row),
    .o_falling_row(falling_row),
    .o_falling_col(falling_col),
    .o_falling_orientation(falling_orientation),
    .o_falling_type(falling_type),
    .o_falling_active(falling_active),
    .o_cand_rotate_R_row(c_rr_row),
    .o_cand_rotate_R_col(c_rr_col),
    .o_cand_rotate_R_orientation(c_rr_ori),
    .o_cand_rotate_L_row(c_rl_row),
    .o_cand_rotate_L_col(c_rl_col),
    .o_cand_rotate_L_orientation(c_rl_ori),
    .o_cand_move_R_row(c_mr_row),
    .o_cand_move_R_col(c_mr_col),
    .o_cand_move_R_orientation(c_mr_ori),
    .o_cand_move_L_row(c_ml_row),
    .o_cand_move_L_col(c_ml_col),
    .o_cand_move_L_orientation(c_ml_ori),
    .o_cand_soft_drop_row(c_sd_row),
    .o_cand_soft_drop_col(c_sd_col),
    .o_cand_soft_drop_orientation(c_sd_ori),
    .o_lock_req(lock_req),
    .i_lock_ack(lock_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("t=%0t check %s observed=%0d expected=%0d", $time, tag, obs, exp);
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_l = 1'b0;
    spawn_valid = 1'b0; spawn_type = 3'd0;
    rotate_R = 1'b0; rotate_L = 1'b0; move_R = 1'b0; move_L = 1'b0;
    soft_drop = 1'b0; hard_drop = 1'b0;
    rotate_R_valid = 1'b1; rotate_L_valid = 1'b1; move_R_valid = 1'b1;
    move_L_valid = 1'b1; soft_drop_valid = 1'b1;
    rotate_R_row_kick = 5'd0; rotate_R_col_kick = 5'd0;
    rotate_L_row_kick = 5'd0; rotate_L_col_kick = 5'd0;
    hard_drop_row = 5'd0; lock_ack = 1'b0;

    step(2);
    chk("rst_spawn_ready", spawn_ready, 1);
    chk("rst_active", falling_active, 0);
    chk("rst_lock_req", lock_req, 0);
    chk("rst_type", falling_type, 0);
    chk("rst_row", falling_row, 0);
    chk("rst_col", falling_col, 4);
    chk("rst_ori", falling_orientation, 0);
    rst_l = 1'b1;

    // Spawn T and let gravity run with every validator answer positive.
    step(1);
    spawn_valid = 1'b1; spawn_type = 3'd3;
    step(1);
    spawn_valid = 1'b0;
    chk("spawn_active", falling_active, 1);
    chk("spawn_ready_low", spawn_ready, 0);
    chk("spawn_type", falling_type, 3);
    step(3);
    chk("grav_row_c3", falling_row, 0);
    step(1);
    chk("grav_row_c4", falling_row, 1);
    step(4);
    chk("grav_row_c8", falling_row, 2);
    chk("grav_col", falling_col, 4);
    chk("grav_ori", falling_orientation, 0);

    // rotate_R outranks move_R; origin comes from the kick.
    move_R = 1'b1; rotate_R = 1'b1; rotate_R_row_kick = 5'd3; rotate_R_col_kick = 5'd6;
    step(1);
    move_R = 1'b0; rotate_R = 1'b0;
    chk("rot_row", falling_row, 3);
    chk("rot_col", falling_col, 6);
    chk("rot_ori", falling_orientation, 1);
    chk("cand_rotR_ori", c_rr_ori, 2);
    chk("cand_rotL_ori", c_rl_ori, 0);

    // Gravity expiry coinciding with move_L: move wins, drop lands one cycle later.
    step(2);
    move_L = 1'b1;
    step(1);
    move_L = 1'b0;
    chk("defer_row", falling_row, 3);
    chk("defer_col", falling_col, 5);
    step(1);
    chk("deferred_drop_row", falling_row, 4);

    soft_drop = 1'b1;
    step(1);
    soft_drop = 1'b0;
    chk("soft_drop_row", falling_row, 5);
    chk("cand_moveL_col", c_ml_col, 4);
    chk("cand_moveR_col", c_mr_col, 6);
    chk("cand_sd_row", c_sd_row, 6);

    move_R = 1'b1; move_R_valid = 1'b0;
    step(1);
    move_R = 1'b0; move_R_valid = 1'b1;
    chk("invalid_moveR_col", falling_col, 5);

    // Blocked gravity step enters LOCKING; lock delay of 3 clocks.
    soft_drop_valid = 1'b0;
    step(3);
    chk("locking_active", falling_active, 1);
    chk("locking_row", falling_row, 5);
    step(2);
    chk("lock_req_c2", lock_req, 0);
    step(1);
    chk("lock_req_c3", lock_req, 1);
    chk("lockout_active", falling_active, 0);

    move_L = 1'b1;
    step(1);
    move_L = 1'b0;
    chk("lockout_moveL_col", falling_col, 5);
    chk("lockout_hold", lock_req, 1);
    lock_ack = 1'b1;
    step(1);
    lock_ack = 1'b0;
    chk("ack_lock_req", lock_req, 0);
    chk("ack_spawn_ready", spawn_ready, 1);

    // Hard drop outranks move_R and goes straight to LOCK_OUT.
    spawn_valid = 1'b1; spawn_type = 3'd1;
    step(1);
    spawn_valid = 1'b0;
    hard_drop = 1'b1; move_R = 1'b1; hard_drop_row = 5'd18;
    step(1);
    hard_drop = 1'b0; move_R = 1'b0;
    chk("hd_row", falling_row, 18);
    chk("hd_col", falling_col, 4);
    chk("hd_lock_req", lock_req, 1);
    lock_ack = 1'b1;
    step(1);
    lock_ack = 1'b0;

    // Moves during LOCKING keep clearing the lock timer.
    spawn_valid = 1'b1; spawn_type = 3'd2;
    step(1);
    spawn_valid = 1'b0;
    step(4);
    move_L = 1'b1;
`ifdef LOCK_RESET_LIMIT_EN
    step(4);
    chk("limit_lock_req_pre", lock_req, 0);
    step(1);
    chk("limit_lock_req", lock_req, 1);
    move_L = 1'b0;
`else
    step(6);
    chk("unlimited_lock_req", lock_req, 0);
    move_L = 1'b0;
    step(2);
    chk("after_moves_c2", lock_req, 0);
    step(1);
    chk("after_moves_c3", lock_req, 1);
`endif
    lock_ack = 1'b1;
    step(1);
    lock_ack = 1'b0;

    // Reset in the middle of LOCKING drops the piece immediately.
    spawn_valid = 1'b1; spawn_type = 3'd5;
    step(1);
    spawn_valid = 1'b0;
    step(5);
    chk("pre_rst_active", falling_active, 1);
    chk("pre_rst_lock_req", lock_req, 0);
    rst_l = 1'b0;
    #1;
    chk("midrst_lock_req", lock_req, 0);
    chk("midrst_active", falling_active, 0);
    chk("midrst_type", falling_type, 0);
    step(1);
    rst_l = 1'b1;
    step(1);
    chk("post_rst_spawn_ready", spawn_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
